alu_cmd_sequencer: RTL
======================

# alu_cmd_sequencer

- Command-side driver for the combinational ALU in the ControlUnit.
- Accepts an operation command (opcode, two operands) over a valid/ready handshake, drives the ALU's `a`/`b`/`sel` inputs from registers, captures the ALU's result and flags, and returns a response over a second valid/ready handshake.
- Maintains an architectural N/Z/C flag register and a completed-operation counter for the control unit.

## Interface

**Parameters**
- `WIDTH`, default 4: operand/result width; must match the attached ALU's `width`.
- `CNT_W`, default 8: width of the completed-operation counter.

**Ports**
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `cmd_valid`, in, 1: command present.
- `cmd_ready`, out, 1: sequencer can accept a command.
- `cmd_op`, in, 4: opcode.
- `cmd_a`, in, WIDTH: operand A.
- `cmd_b`, in, WIDTH: operand B.
- `rsp_valid`, out, 1: response present.
- `rsp_ready`, in, 1: consumer takes the response.
- `rsp_result`, out, WIDTH: captured result.
- `rsp_err`, out, 1: opcode was unsupported.
- `alu_a`, out, WIDTH: ALU operand A, registered.
- `alu_b`, out, WIDTH: ALU operand B, registered.
- `alu_sel`, out, 4: ALU select, registered.
- `alu_result`, in, WIDTH: ALU result.
- `alu_cout`, in, 1: ALU carry.
- `alu_negative`, in, 1: ALU negative flag.
- `alu_zero`, in, 1: ALU zero flag.
- `flag_clr`, in, 1: synchronous clear of the flag register.
- `flag_n`, out, 1: architectural negative flag.
- `flag_z`, out, 1: architectural zero flag.
- `flag_c`, out, 1: architectural carry flag.
- `op_count`, out, CNT_W: count of completed legal operations.

## Operation

**Supported opcodes**
- `OP_ADD` = 4'b0000.
- `OP_SUB` = 4'b0001.
- All other codes are illegal.

**FSM states:** IDLE, ISSUE, RESP.

- **IDLE**
  - `cmd_ready`=1.
  - On `cmd_valid` with a legal opcode: latch the operands and opcode into `alu_a`/`alu_b`/`alu_sel`, then go to ISSUE.
  - On `cmd_valid` with an illegal opcode: leave the `alu_*` outputs unchanged; load `rsp_result`=0 and `rsp_err`=1; go to RESP.
- **ISSUE**
  - `cmd_ready`=0; the ALU evaluates combinationally.
  - At the end of the cycle: `rsp_result`←`alu_result`, `rsp_err`←0.
  - Flags load `flag_n`←`alu_negative`, `flag_z`←`alu_zero`, `flag_c`←`alu_cout`.
  - `op_count` increments.
  - Go to RESP.
- **RESP**
  - `rsp_valid`=1 and `cmd_ready`=0.
  - `rsp_result`/`rsp_err` hold stable until `rsp_ready`=1, then go to IDLE.
  - A new command cannot be accepted in the cycle the response handshakes.

**Flag and counter rules**
- The ALU returns subtraction as a magnitude with a separate negative flag. The sequencer stores the ALU's values verbatim and performs no re-encoding.
- `flag_clr` zeroes N/Z/C in any state. If `flag_clr` coincides with the ISSUE capture, the capture wins.
- Illegal opcodes never modify the flags or `op_count`.
- `op_count` wraps from 2^CNT_W−1 to 0.
- `alu_*` outputs hold their last issued values outside ISSUE.

**Reset (`rst`=1, any state, including mid-operation)**
- State goes to IDLE.
- `alu_a`, `alu_b`, `alu_sel`, `rsp_result`, `rsp_err`, flags and `op_count` all go to 0.
- `rsp_valid`=0 and `cmd_ready`=1 after release.
- A pending response is discarded.

## Timing

**Legal operation**
- Command accepted at edge E0 (`cmd_valid`&`cmd_ready`).
- `alu_*` are valid during cycle 1.
- Result and flags are captured at E1.
- `rsp_valid`=1 from cycle 2.

**Illegal operation:** `rsp_valid`=1 from cycle 1.

**Back-to-back throughput**
- Legal ops: minimum 3 cycles per op (ISSUE, RESP, IDLE).
- Illegal ops: minimum 2 cycles per op.

**Handshakes**
- `cmd_ready` and `rsp_valid` are decoded from state only, with no combinational path from `cmd_valid` or `rsp_ready`.
- ALU path: registered `alu_*` → ALU → capture registers, a single cycle.

## Structure

- **Package `alu_seq_pkg`**
  - `OP_ADD` and `OP_SUB` opcode constants.
  - State enum `seq_state_t` (IDLE/ISSUE/RESP).
  - Function `is_legal_op(logic [3:0])`.
- **Sub-modules**
  - The FSM, capture and flag registers live in one module; no sub-module is needed.
  - The flag register may optionally be split out as `alu_flag_reg` (inputs: load, clear, N/Z/C).

## Test plan

Bench uses WIDTH=4 and instantiates the real ALU.

1. ADD 7+9 → `rsp_result`=0, `flag_c`=1, `flag_z`=1, `flag_n`=0; `rsp_valid` rises 2 cycles after accept; `op_count`=1.
2. SUB 3−5 → `rsp_result`=2, `flag_n`=1, `flag_c`=0, `flag_z`=0. SUB 5−3 → `rsp_result`=2, `flag_n`=0.
3. Opcode 4'b0110 with a=4, b=1 → `rsp_err`=1, `rsp_result`=0, `rsp_valid` 1 cycle after accept; flags, `op_count` and `alu_sel` unchanged.
4. Hold `rsp_ready`=0 for 5 cycles → `rsp_valid`/`rsp_result` stable and `cmd_ready`=0 throughout; with `cmd_valid` held, the next command is accepted exactly 1 cycle after the response handshake.
5. `flag_clr` asserted in the ISSUE cycle of ADD 8+8 → flags end at C=1, Z=1. `flag_clr` alone in IDLE → flags 0.
6. Assert `rst` during ISSUE → next cycle: IDLE, `rsp_valid`=0, all outputs 0, no response ever emitted. Separately, 256 legal ops → `op_count` wraps to 0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode constants, sequencer state encoding and opcode legality check
// for the ALU command sequencer.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } seq_state_t;

  function automatic logic is_legal_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_cmd_sequencer.sv
// Drives a combinational ALU from registered operands, captures its result and
// flags one cycle later, and returns the result over a valid/ready response.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             flag_clr,
  output logic             flag_n,
  output logic             flag_z,
  output logic             flag_c,
  output logic [CNT_W-1:0] op_count
);

  seq_state_t r_state;

  // Handshake outputs depend on state only, never on cmd_valid/rsp_ready.
  assign cmd_ready = (r_state == ST_IDLE);
  assign rsp_valid = (r_state == ST_RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_sel    <= 4'b0000;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (is_legal_op(cmd_op)) begin
              alu_a   <= cmd_a;
              alu_b   <= cmd_b;
              alu_sel <= cmd_op;
              r_state <= ST_ISSUE;
            end else begin
              rsp_result <= '0;
              rsp_err    <= 1'b1;
              r_state    <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          rsp_result <= alu_result;
          rsp_err    <= 1'b0;
          op_count   <= op_count + CNT_W'(1);
          r_state    <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Architectural flags: the ISSUE capture takes priority over a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end else if (r_state == ST_ISSUE) begin
      flag_n <= alu_negative;
      flag_z <= alu_zero;
      flag_c <= alu_cout;
    end else if (flag_clr) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_c <= 1'b0;
    end
  end

endmodule
